// File: rtl/vga_bounce_scroller.sv
// vga_bounce_scroller: per-frame X/Y offset engine and pattern colouriser.
// Sits between hvsync_generator and the TinyVGA PMOD outputs. Offsets bounce
// between 0 and the axis limit, or wrap, once every 2^speed frames. The offset
// pixel coordinates are mapped to registered 2-bit R/G/B values, and the syncs
// are delayed by the same one clock so that they stay aligned with the colour.
module vga_bounce_scroller #(
  parameter int PIX_W  = 10,
  parameter int X_MAX  = 512,
  parameter int Y_MAX  = 256,
  parameter int X_STEP = 1,
  parameter int Y_STEP = 2,
  parameter int CBIT   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_x,
  input  logic [PIX_W-1:0] pix_y,
  input  logic             video_active,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [1:0]       r,
  output logic [1:0]       g,
  output logic [1:0]       b,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [PIX_W-1:0] ofs_x,
  output logic [PIX_W-1:0] ofs_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic             frame_tick
);

  // Limits and steps widened by one bit so that ofs+S never overflows a compare.
  localparam logic [PIX_W:0] XM = (PIX_W+1)'(X_MAX);
  localparam logic [PIX_W:0] YM = (PIX_W+1)'(Y_MAX);
  localparam logic [PIX_W:0] XS = (PIX_W+1)'(X_STEP);
  localparam logic [PIX_W:0] YS = (PIX_W+1)'(Y_STEP);

  // One-hot masks that select the colour bits of the offset coordinates.
  localparam logic [PIX_W-1:0] MASK_R = PIX_W'(1) << CBIT;
  localparam logic [PIX_W-1:0] MASK_G = PIX_W'(1) << (CBIT + 1);
  localparam logic [PIX_W-1:0] MASK_B = PIX_W'(1) << (CBIT + 2);

  // Advance one axis. The result is {dir, ofs}.
  function automatic logic [PIX_W:0] step_axis(
    input logic [PIX_W-1:0] ofs,
    input logic             dir,
    input logic             wrap,
    input logic [PIX_W:0]   m,
    input logic [PIX_W:0]   s
  );
    logic [PIX_W:0] sum;
    logic [PIX_W:0] wide;
    sum  = {1'b0, ofs} + s;
    wide = {1'b0, ofs};
    if (wrap) begin
      // Wrap modulo M+1; the direction is held so that bounce resumes with it.
      if (sum > m) step_axis = {dir, PIX_W'(sum - m - 1'b1)};
      else         step_axis = {dir, sum[PIX_W-1:0]};
    end else if (dir) begin
      if (sum >= m) step_axis = {1'b0, m[PIX_W-1:0]};
      else          step_axis = {1'b1, sum[PIX_W-1:0]};
    end else begin
      if (wide <= s) step_axis = {1'b1, {PIX_W{1'b0}}};
      else           step_axis = {1'b0, PIX_W'(wide - s)};
    end
  endfunction

  // Pack the colour bit of each offset coordinate as {x-bit, y-bit}.
  function automatic logic [1:0] colour(
    input logic             va,
    input logic [PIX_W-1:0] mx,
    input logic [PIX_W-1:0] my,
    input logic [PIX_W-1:0] mask
  );
    colour = va ? {|(mx & mask), |(my & mask)} : 2'b00;
  endfunction

  logic             vs_q;
  logic [2:0]       div_cnt_q, div_cnt_d;
  logic [2:0]       div_lim;
  logic             upd;
  logic [PIX_W-1:0] ofs_x_q, ofs_x_d, ofs_y_q, ofs_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [PIX_W-1:0] mx, my;
  logic [1:0]       r_q, g_q, b_q;
  logic             hs_q, vso_q;

  // Frame tick, divider and next-offset selection.
  always_comb begin
    frame_tick = vsync_in & ~vs_q & rst_n;
    case (speed)
      2'd0:    div_lim = 3'd0;
      2'd1:    div_lim = 3'd1;
      2'd2:    div_lim = 3'd3;
      default: div_lim = 3'd7;
    endcase
    div_cnt_d = div_cnt_q;
    upd       = 1'b0;
    if (frame_tick) begin
      if (div_cnt_q >= div_lim) begin
        div_cnt_d = 3'd0;
        upd       = ~mode[1];
      end else begin
        div_cnt_d = div_cnt_q + 3'd1;
      end
    end
    {dir_x_d, ofs_x_d} = {dir_x_q, ofs_x_q};
    {dir_y_d, ofs_y_d} = {dir_y_q, ofs_y_q};
    if (upd) begin
      {dir_x_d, ofs_x_d} = step_axis(ofs_x_q, dir_x_q, mode[0], XM, XS);
      {dir_y_d, ofs_y_d} = step_axis(ofs_y_q, dir_y_q, mode[0], YM, YS);
    end
    mx = pix_x + ofs_x_q;
    my = pix_y + ofs_y_q;
  end

  // Offset state, divider and vsync history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      div_cnt_q <= 3'd0;
      ofs_x_q   <= '0;
      ofs_y_q   <= '0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
    end else begin
      vs_q      <= vsync_in;
      div_cnt_q <= div_cnt_d;
      ofs_x_q   <= ofs_x_d;
      ofs_y_q   <= ofs_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
    end
  end

  // Registered colour and sync outputs, one clock behind the pixel inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= 2'b00;
      g_q   <= 2'b00;
      b_q   <= 2'b00;
      hs_q  <= 1'b0;
      vso_q <= 1'b0;
    end else begin
      r_q   <= colour(video_active, mx, my, MASK_R);
      g_q   <= colour(video_active, mx, my, MASK_G);
      b_q   <= colour(video_active, mx, my, MASK_B);
      hs_q  <= hsync_in;
      vso_q <= vsync_in;
    end
  end

  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign hsync_out = hs_q;
  assign vsync_out = vso_q;
  assign ofs_x     = ofs_x_q;
  assign ofs_y     = ofs_y_q;
  assign dir_x     = dir_x_q;
  assign dir_y     = dir_y_q;

endmodule

// File: tb/tb_vga_bounce_scroller.sv
// Directed bench for vga_bounce_scroller: a default-parameter instance (a_*)
// and a small-limit instance (b_*, X_MAX=10, X_STEP=3) share all inputs.
module tb_vga_bounce_scroller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic       video_active = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [1:0] mode = 2'd0, speed = 2'd0;

  logic [1:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic       a_hs, a_vs, b_hs, b_vs;
  logic [9:0] a_ox, a_oy, b_ox, b_oy;
  logic       a_dx, a_dy, b_dx, b_dy, a_ft, b_ft;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_bounce_scroller dut_a (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .video_active(video_active), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mode(mode), .speed(speed), .r(a_r), .g(a_g), .b(a_b),
    .hsync_out(a_hs), .vsync_out(a_vs), .ofs_x(a_ox), .ofs_y(a_oy),
    .dir_x(a_dx), .dir_y(a_dy), .frame_tick(a_ft)
  );

  vga_bounce_scroller #(.X_MAX(10), .Y_MAX(10), .X_STEP(3), .Y_STEP(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .video_active(video_active), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mode(mode), .speed(speed), .r(b_r), .g(b_g), .b(b_b),
    .hsync_out(b_hs), .vsync_out(b_vs), .ofs_x(b_ox), .ofs_y(b_oy),
    .dir_x(b_dx), .dir_y(b_dy), .frame_tick(b_ft)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vsync_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One vsync pulse: high for one clock, then low for one clock.
  task automatic do_tick();
    @(negedge clk);
    vsync_in = 1'b1;
    @(negedge clk);
    vsync_in = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hsync_in = 1'b1;
    video_active = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vsync_in = ~vsync_in;
      #1;
      checks++;
      if (a_ft !== 1'b0) begin
        failures++;
        $display("FAIL reset_tick got=%0b exp=0", a_ft);
      end
      checks++;
      if ({a_ox, a_oy, a_dx, a_dy} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL reset_ofs got x=%0d y=%0d dx=%0b dy=%0b exp 0 0 1 1", a_ox, a_oy, a_dx, a_dy);
      end
      checks++;
      if ({a_r, a_g, a_b, a_hs, a_vs} !== 8'd0) begin
        failures++;
        $display("FAIL reset_out got r=%0d g=%0d b=%0d hs=%0b vs=%0b exp all 0", a_r, a_g, a_b, a_hs, a_vs);
      end
    end
    hsync_in = 1'b0;
    video_active = 1'b0;
    @(negedge clk);
    vsync_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vsync_in = 1'b1;
    #1;
    checks++;
    if (a_ft !== 1'b1) begin
      failures++;
      $display("FAIL first_tick got=%0b exp=1", a_ft);
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_ft !== 1'b0) begin
      failures++;
      $display("FAIL tick_width got=%0b exp=0", a_ft);
    end
    vsync_in = 1'b0;
  endtask

  task automatic test_bounce_default();
    do_reset();
    mode = 2'd0;
    speed = 2'd0;
    for (int i = 1; i <= 513; i++) begin
      do_tick();
      if (i == 128 || i == 129) begin
        checks++;
        if ({a_oy, a_dy} !== ((i == 128) ? {10'd256, 1'b0} : {10'd254, 1'b0})) begin
          failures++;
          $display("FAIL y_bounce_%0d got y=%0d dy=%0b exp y=%0d dy=0", i, a_oy, a_dy, (i == 128) ? 256 : 254);
        end
      end
      if (i == 100 || i == 512 || i == 513) begin
        checks++;
        if ({a_ox, a_dx} !== ((i == 100) ? {10'd100, 1'b1} : (i == 512) ? {10'd512, 1'b0} : {10'd511, 1'b0})) begin
          failures++;
          $display("FAIL x_bounce_%0d got x=%0d dx=%0b", i, a_ox, a_dx);
        end
      end
    end
  endtask

  task automatic test_bounce_small();
    int exp_o[9] = '{3, 6, 9, 10, 7, 4, 1, 0, 3};
    logic exp_d[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    mode = 2'd0;
    speed = 2'd0;
    for (int i = 0; i < 9; i++) begin
      do_tick();
      checks++;
      if (b_ox !== 10'(exp_o[i]) || b_dx !== exp_d[i]) begin
        failures++;
        $display("FAIL small_bounce_%0d got x=%0d dx=%0b exp x=%0d dx=%0b", i, b_ox, b_dx, exp_o[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_wrap_pause();
    int exp_o[5] = '{3, 6, 9, 1, 4};
    do_reset();
    mode = 2'd1;
    speed = 2'd0;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      checks++;
      if (b_ox !== 10'(exp_o[i]) || b_dx !== 1'b1) begin
        failures++;
        $display("FAIL wrap_%0d got x=%0d dx=%0b exp x=%0d dx=1", i, b_ox, b_dx, exp_o[i]);
      end
    end
    mode = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vsync_in = 1'b1;
      #1;
      checks++;
      if (b_ft !== 1'b1) begin
        failures++;
        $display("FAIL pause_tick_%0d got=%0b exp=1", i, b_ft);
      end
      @(negedge clk);
      vsync_in = 1'b0;
      checks++;
      if (b_ox !== 10'd4) begin
        failures++;
        $display("FAIL pause_hold_%0d got x=%0d exp x=4", i, b_ox);
      end
    end
    mode = 2'd0;
  endtask

  task automatic test_speed_divider();
    do_reset();
    mode = 2'd0;
    speed = 2'd2;
    repeat (3) do_tick();
    checks++;
    if (a_ox !== 10'd0) begin
      failures++;
      $display("FAIL div_3ticks got x=%0d exp x=0", a_ox);
    end
    do_tick();
    checks++;
    if (a_ox !== 10'd1 || a_oy !== 10'd2) begin
      failures++;
      $display("FAIL div_4ticks got x=%0d y=%0d exp x=1 y=2", a_ox, a_oy);
    end
    repeat (2) do_tick();
    do_reset();
    repeat (3) do_tick();
    checks++;
    if (a_ox !== 10'd0) begin
      failures++;
      $display("FAIL div_rst_3ticks got x=%0d exp x=0", a_ox);
    end
    do_tick();
    checks++;
    if (a_ox !== 10'd1) begin
      failures++;
      $display("FAIL div_rst_4ticks got x=%0d exp x=1", a_ox);
    end
    speed = 2'd0;
  endtask

  task automatic test_pixel_path();
    logic prev_hs;
    logic [4:0] hs_pat = 5'b01101;
    do_reset();
    mode = 2'd0;
    speed = 2'd0;
    repeat (32) do_tick();
    checks++;
    if (a_ox !== 10'd32 || a_oy !== 10'd64) begin
      failures++;
      $display("FAIL pix_setup got x=%0d y=%0d exp x=32 y=64", a_ox, a_oy);
    end
    mode = 2'd2;
    // pix_y=960 cancels ofs_y=64, so my=0 and only mx=32 sets a colour bit.
    @(negedge clk);
    pix_x = 10'd0;
    pix_y = 10'd960;
    video_active = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_r, a_g, a_b} !== {2'b10, 2'b00, 2'b00}) begin
      failures++;
      $display("FAIL pix_x32 got r=%0b g=%0b b=%0b exp r=10 g=00 b=00", a_r, a_g, a_b);
    end
    // mx=96 sets bits 5,6; my=32 sets bit 5.
    pix_x = 10'd64;
    pix_y = 10'd992;
    @(negedge clk);
    checks++;
    if ({a_r, a_g, a_b} !== {2'b11, 2'b10, 2'b00}) begin
      failures++;
      $display("FAIL pix_mix got r=%0b g=%0b b=%0b exp r=11 g=10 b=00", a_r, a_g, a_b);
    end
    video_active = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_r, a_g, a_b} !== 6'd0) begin
      failures++;
      $display("FAIL pix_blank got r=%0b g=%0b b=%0b exp 0", a_r, a_g, a_b);
    end
    prev_hs = hsync_in;
    for (int i = 0; i < 5; i++) begin
      hsync_in = hs_pat[i];
      #1;
      checks++;
      if (a_hs !== prev_hs) begin
        failures++;
        $display("FAIL hsync_hold_%0d got=%0b exp=%0b", i, a_hs, prev_hs);
      end
      @(negedge clk);
      checks++;
      if (a_hs !== hs_pat[i]) begin
        failures++;
        $display("FAIL hsync_delay_%0d got=%0b exp=%0b", i, a_hs, hs_pat[i]);
      end
      prev_hs = hs_pat[i];
    end
    mode = 2'd0;
  endtask

  initial begin
    test_reset();
    test_bounce_default();
    test_bounce_small();
    test_wrap_pause();
    test_speed_divider();
    test_pixel_path();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
